// File: rtl/tl_source_tracker.sv
// TileLink A/D source tracker: per-source open-request table, D response checks and watchdog.
// Optional simulation-only $fatal on the first error flag: define TL_TRACKER_FATAL_EN.
module tl_source_tracker #(
    parameter int unsigned SOURCE_W = 7,
    parameter int unsigned SIZE_W   = 4,
    parameter int unsigned BEAT_LG  = 3,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_valid,
    input  logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic                d_valid,
    input  logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [SOURCE_W-1:0] d_source,
    input  logic [SIZE_W-1:0]   d_size,
    output logic [SOURCE_W:0]   inflight,
    output logic                err_dup_source,
    output logic                err_unexpected_d,
    output logic                err_mismatch,
    output logic                err_timeout,
    output logic [SOURCE_W-1:0] err_source
);

    localparam int unsigned DEPTH = 2**SOURCE_W;
    localparam int unsigned IF_W  = SOURCE_W + 1;
    localparam int unsigned CNT_W = 2**SIZE_W - BEAT_LG;
    localparam int unsigned WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        CLS_ACK      = 2'd0,
        CLS_ACK_DATA = 2'd1,
        CLS_HINT     = 2'd2
    } resp_cls_e;

    typedef struct packed {
        resp_cls_e         cls;
        logic [SIZE_W-1:0] size;
    } entry_t;

    logic [DEPTH-1:0]    r_valid;
    entry_t              r_entry [DEPTH];
    logic [CNT_W-1:0]    r_a_cnt;
    logic [CNT_W-1:0]    r_d_cnt;
    logic [IF_W-1:0]     r_inflight;
    logic [WD_W-1:0]     r_wd;
    logic                r_err_dup;
    logic                r_err_unexp;
    logic                r_err_mism;
    logic                r_err_to;
    logic [SOURCE_W-1:0] r_err_src;

    logic                w_a_fire, w_d_fire;
    logic                w_a_first, w_a_last, w_d_first, w_d_last;
    logic                w_a_hit, w_d_hit;
    logic                w_alloc, w_retire, w_inc;
    logic                w_set_dup, w_set_unexp, w_set_mism, w_set_to;
    logic                w_none, w_wd_clr, w_wd_max;
    logic [SOURCE_W-1:0] w_err_src;
    resp_cls_e           w_a_cls;

    // Index of the last beat of a message (counters run 0 .. beats-1).
    function automatic logic [CNT_W-1:0] last_beat(input logic [SIZE_W-1:0] size,
                                                   input logic              multi);
        if (multi && (size > SIZE_W'(BEAT_LG)))
            return (CNT_W'(1) << (size - SIZE_W'(BEAT_LG))) - CNT_W'(1);
        return '0;
    endfunction

    assign w_a_fire  = a_valid & a_ready;
    assign w_d_fire  = d_valid & d_ready;
    assign w_a_first = (r_a_cnt == '0);
    assign w_d_first = (r_d_cnt == '0);
    assign w_a_last  = (r_a_cnt == last_beat(a_size, (a_opcode == 3'd0) || (a_opcode == 3'd1)));
    assign w_d_last  = (r_d_cnt == last_beat(d_size, (d_opcode == 3'd1)));
    assign w_a_hit   = r_valid[a_source];
    assign w_d_hit   = r_valid[d_source];

    always_comb begin
        w_a_cls = CLS_ACK;
        case (a_opcode)
            3'd2, 3'd3, 3'd4: w_a_cls = CLS_ACK_DATA;
            3'd5:             w_a_cls = CLS_HINT;
            default:          w_a_cls = CLS_ACK;
        endcase
    end

    // A retire and an allocate on the same source in one cycle is a hand-over, not a duplicate.
    assign w_alloc     = w_a_fire & w_a_first;
    assign w_retire    = w_d_fire & w_d_last & w_d_hit;
    assign w_set_dup   = w_alloc & w_a_hit & ~(w_retire & (a_source == d_source));
    assign w_inc       = w_alloc & ~w_set_dup;
    assign w_set_unexp = w_d_fire & w_d_first & ~w_d_hit;
    assign w_set_mism  = w_d_fire & w_d_first & w_d_hit &
                         (({1'b0, r_entry[d_source].cls} != d_opcode) ||
                          (r_entry[d_source].size != d_size));

    assign w_wd_clr = w_d_fire | (r_inflight == '0);
    assign w_wd_max = (r_wd == WD_W'(TIMEOUT - 1));
    assign w_set_to = ~w_wd_clr & w_wd_max;

    assign w_none    = ~(r_err_dup | r_err_unexp | r_err_mism | r_err_to);
    assign w_err_src = (w_set_unexp | w_set_mism) ? d_source :
                       w_set_dup                  ? a_source : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= '0;
            r_a_cnt    <= '0;
            r_d_cnt    <= '0;
            r_inflight <= '0;
            r_wd       <= '0;
        end else begin
            if (w_retire) r_valid[d_source] <= 1'b0;
            if (w_alloc)  r_valid[a_source] <= 1'b1;
            if (w_a_fire) r_a_cnt <= w_a_last ? '0 : r_a_cnt + CNT_W'(1);
            if (w_d_fire) r_d_cnt <= w_d_last ? '0 : r_d_cnt + CNT_W'(1);
            r_inflight <= r_inflight + IF_W'(w_inc) - IF_W'(w_retire);
            if (w_wd_clr)       r_wd <= '0;
            else if (!w_wd_max) r_wd <= r_wd + WD_W'(1);
        end
    end

    // Payload needs no reset: it is only read behind a set valid bit.
    always_ff @(posedge clock) begin
        if (w_alloc) r_entry[a_source] <= '{cls: w_a_cls, size: a_size};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_dup   <= 1'b0;
            r_err_unexp <= 1'b0;
            r_err_mism  <= 1'b0;
            r_err_to    <= 1'b0;
            r_err_src   <= '0;
        end else begin
            if (w_none && (w_set_dup | w_set_unexp | w_set_mism | w_set_to))
                r_err_src <= w_err_src;
            if (w_set_dup)   r_err_dup   <= 1'b1;
            if (w_set_unexp) r_err_unexp <= 1'b1;
            if (w_set_mism)  r_err_mism  <= 1'b1;
            if (w_set_to)    r_err_to    <= 1'b1;
        end
    end

    assign inflight         = r_inflight;
    assign err_dup_source   = r_err_dup;
    assign err_unexpected_d = r_err_unexp;
    assign err_mismatch     = r_err_mism;
    assign err_timeout      = r_err_to;
    assign err_source       = r_err_src;

`ifdef TL_TRACKER_FATAL_EN
    always_ff @(posedge clock) begin
        if (reset_n && w_none && (w_set_dup | w_set_unexp | w_set_mism | w_set_to))
            $fatal(1, "tl_source_tracker: %s source=%0d time=%0t",
                   w_set_unexp ? "err_unexpected_d" :
                   w_set_mism  ? "err_mismatch"     :
                   w_set_dup   ? "err_dup_source"   : "err_timeout",
                   w_err_src, $time);
    end
`else
    // Flags only; no simulation stop.
`endif

endmodule

// File: tb/tb_tl_source_tracker.sv
// Testbench for tl_source_tracker: directed scenarios plus randomized traffic against a transaction-level model.
module tb_tl_source_tracker;

    localparam int unsigned SOURCE_W = 7;
    localparam int unsigned SIZE_W   = 4;
    localparam int unsigned BEAT_LG  = 3;
    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned DEPTH    = 1 << SOURCE_W;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                a_valid, a_ready, d_valid, d_ready;
    logic [2:0]          a_opcode, d_opcode;
    logic [SOURCE_W-1:0] a_source, d_source;
    logic [SIZE_W-1:0]   a_size, d_size;
    logic [SOURCE_W:0]   inflight;
    logic                err_dup_source, err_unexpected_d, err_mismatch, err_timeout;
    logic [SOURCE_W-1:0] err_source;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    tl_source_tracker #(
        .SOURCE_W(SOURCE_W), .SIZE_W(SIZE_W), .BEAT_LG(BEAT_LG), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
        .a_source(a_source), .a_size(a_size),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_source(d_source), .d_size(d_size),
        .inflight(inflight), .err_dup_source(err_dup_source),
        .err_unexpected_d(err_unexpected_d), .err_mismatch(err_mismatch),
        .err_timeout(err_timeout), .err_source(err_source)
    );

    // Transaction-level reference state
    bit         m_open [DEPTH];
    logic [1:0] m_cls  [DEPTH];
    logic [3:0] m_sz   [DEPTH];
    int         m_arem, m_drem, m_quiet, m_src;
    bit         m_dup, m_unexp, m_mism, m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int inf, input bit dup, input bit unexp,
                             input bit mism, input bit to, input int src);
        chk({tag, ".inflight"}, 32'(inflight), 32'(inf));
        chk({tag, ".err_dup_source"}, 32'(err_dup_source), 32'(dup));
        chk({tag, ".err_unexpected_d"}, 32'(err_unexpected_d), 32'(unexp));
        chk({tag, ".err_mismatch"}, 32'(err_mismatch), 32'(mism));
        chk({tag, ".err_timeout"}, 32'(err_timeout), 32'(to));
        chk({tag, ".err_source"}, 32'(err_source), 32'(src));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; a_ready = 0; a_opcode = 0; a_source = 0; a_size = 0;
        d_valid = 0; d_ready = 0; d_opcode = 0; d_source = 0; d_size = 0;
    endtask

    task automatic set_a(input int op, input int src, input int sz);
        a_valid = 1; a_ready = 1;
        a_opcode = 3'(op); a_source = SOURCE_W'(src); a_size = SIZE_W'(sz);
    endtask

    task automatic set_d(input int op, input int src, input int sz);
        d_valid = 1; d_ready = 1;
        d_opcode = 3'(op); d_source = SOURCE_W'(src); d_size = SIZE_W'(sz);
    endtask

    task automatic a_only(input int op, input int src, input int sz);
        set_a(op, src, sz); tick(); idle();
    endtask

    task automatic d_only(input int op, input int src, input int sz);
        set_d(op, src, sz); tick(); idle();
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    function automatic int n_beats(input logic [3:0] sz, input bit multi);
        return (multi && sz > BEAT_LG) ? (1 << (sz - BEAT_LG)) : 1;
    endfunction

    function automatic logic [1:0] resp_of(input logic [2:0] op);
        if (op == 3'd2 || op == 3'd3 || op == 3'd4) return 2'd1;
        if (op == 3'd5) return 2'd2;
        return 2'd0;
    endfunction

    function automatic int open_count();
        int n = 0;
        foreach (m_open[i]) n += int'(m_open[i]);
        return n;
    endfunction

    task automatic model_reset();
        foreach (m_open[i]) m_open[i] = 0;
        m_arem = 0; m_drem = 0; m_quiet = 0; m_src = 0;
        m_dup = 0; m_unexp = 0; m_mism = 0; m_to = 0;
    endtask

    // One randomized cycle: choose inputs, predict the edge, advance and compare.
    task automatic rand_cycle(input int cyc);
        int  q[$];
        int  pre, as, ds, dbeats;
        bit  afire, dfire, afirst, dfirst, dlast, retire, e_dup, e_unexp, e_mism, e_to, none;
        if (m_arem == 0) begin
            a_opcode = 3'($urandom_range(0, 7));
            a_source = SOURCE_W'($urandom_range(0, 15));
            a_size   = SIZE_W'($urandom_range(0, 6));
            a_valid  = ($urandom_range(0, 2) == 0);
        end else begin
            a_valid  = ($urandom_range(0, 2) != 0);
        end
        a_ready = ($urandom_range(0, 3) != 0);
        if (m_drem == 0) begin
            for (int i = 0; i < 16; i++) if (m_open[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
                ds       = q[$urandom_range(0, q.size() - 1)];
                d_source = SOURCE_W'(ds);
                d_opcode = {1'b0, m_cls[ds]};
                d_size   = m_sz[ds];
            end else begin
                d_source = SOURCE_W'($urandom_range(0, 15));
                d_opcode = 3'($urandom_range(0, 2));
                d_size   = SIZE_W'($urandom_range(0, 6));
            end
        end
        d_valid = ($urandom_range(0, 1) == 0);
        d_ready = ($urandom_range(0, 3) != 0);

        pre    = open_count();
        as     = int'(a_source);
        ds     = int'(d_source);
        afire  = a_valid && a_ready;
        dfire  = d_valid && d_ready;
        afirst = (m_arem == 0);
        dfirst = (m_drem == 0);
        dbeats = n_beats(d_size, d_opcode == 3'd1);
        dlast  = dfirst ? (dbeats == 1) : (m_drem == 1);
        e_unexp = dfire && dfirst && !m_open[ds];
        e_mism  = dfire && dfirst && m_open[ds] &&
                  ((m_cls[ds] != d_opcode[1:0]) || d_opcode[2] || (m_sz[ds] != d_size));
        retire  = dfire && dlast;
        e_dup   = afire && afirst && m_open[as] && !(retire && ds == as);
        m_quiet = (dfire || pre == 0) ? 0 : m_quiet + 1;
        e_to    = (m_quiet == TIMEOUT);
        none    = !(m_dup || m_unexp || m_mism || m_to);
        if (none) begin
            if (e_unexp || e_mism) m_src = ds;
            else if (e_dup)        m_src = as;
            else if (e_to)         m_src = 0;
        end
        m_dup |= e_dup; m_unexp |= e_unexp; m_mism |= e_mism; m_to |= e_to;
        if (retire) m_open[ds] = 0;
        if (afire && afirst) begin
            m_open[as] = 1;
            m_cls[as]  = resp_of(a_opcode);
            m_sz[as]   = a_size;
        end
        if (afire) m_arem = afirst ? n_beats(a_size, a_opcode <= 3'd1) - 1 : m_arem - 1;
        if (dfire) m_drem = dfirst ? dbeats - 1 : m_drem - 1;
        tick();
        check_all($sformatf("rand%0d", cyc), open_count(), m_dup, m_unexp, m_mism, m_to, m_src);
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        tick();
        check_all("reset", 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();

`ifdef TL_TRACKER_FATAL_EN
        a_only(4, 1, 3);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check_all("pre_fatal", 1, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        tick();
        tick();
        $fatal(1, "FAIL fatal_expected observed=no_fatal expected=fatal");
`else
        // Get answered by AccessAckData
        a_only(4, 5, 3);
        chk("get.inflight_open", 32'(inflight), 1);
        d_only(1, 5, 3);
        check_all("get.done", 0, 0, 0, 0, 0, 0);

        // 4-beat PutFull; the following Get must be seen as a new first beat
        for (int i = 0; i < 4; i++) begin
            a_only(0, 9, 5);
            chk($sformatf("put.beat%0d", i), 32'(inflight), 1);
        end
        a_only(4, 10, 3);
        chk("put.wrap_alloc", 32'(inflight), 2);
        d_only(0, 9, 5);
        chk("put.ack_retire", 32'(inflight), 1);
        d_only(1, 10, 3);
        check_all("put.done", 0, 0, 0, 0, 0, 0);

        // Retire and re-allocate the same source in one cycle
        a_only(4, 20, 3);
        set_a(4, 20, 3); set_d(1, 20, 3); tick(); idle();
        check_all("handover", 1, 0, 0, 0, 0, 0);
        d_only(1, 20, 3);
        chk("handover.retire", 32'(inflight), 0);

        // Multi-beat AccessAckData retires only on the 4th beat
        a_only(4, 21, 5);
        for (int i = 0; i < 3; i++) begin
            d_only(1, 21, 5);
            chk($sformatf("ackdata.beat%0d", i), 32'(inflight), 1);
        end
        d_only(1, 21, 5);
        check_all("ackdata.done", 0, 0, 0, 0, 0, 0);

        do_reset();
        a_only(4, 3, 3);
        chk("dup.first", 32'(err_dup_source), 0);
        a_only(4, 3, 3);
        check_all("dup", 1, 1, 0, 0, 0, 3);

        do_reset();
        d_only(1, 12, 3);
        check_all("stray", 0, 0, 1, 0, 0, 12);

        do_reset();
        a_only(4, 7, 2);
        d_only(0, 7, 2);
        check_all("mismatch", 0, 0, 0, 1, 0, 7);

        // A and D first beats together on a closed source: no bypass
        do_reset();
        set_a(4, 30, 3); set_d(1, 30, 3); tick(); idle();
        check_all("nobypass", 1, 0, 1, 0, 0, 30);
        d_only(1, 30, 3);
        check_all("nobypass.retire", 0, 0, 1, 0, 0, 30);

        do_reset();
        a_only(4, 40, 3);
        do_reset();
        d_only(1, 40, 3);
        check_all("post_reset", 0, 0, 1, 0, 0, 40);

        // Dup and unexpected D in one cycle: D source wins
        do_reset();
        a_only(4, 50, 3);
        set_a(4, 50, 3); set_d(1, 60, 3); tick(); idle();
        check_all("priority", 1, 1, 1, 0, 0, 60);

        // Watchdog: flag rises 16 edges after the A fire edge
        do_reset();
        a_only(4, 1, 3);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check_all("timeout.before", 1, 0, 0, 0, 0, 0);
        tick();
        check_all("timeout", 1, 0, 0, 0, 1, 0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) begin
                do_reset();
                model_reset();
            end
            rand_cycle(cyc);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
`endif
    end

endmodule
